memory_cycle: RTL

- MEM stage of the 5-stage RV32 pipeline; consumes the EX/MEM pipeline register outputs (ALU result, store data, control, Rd, PC+4).
- Performs the data-memory load/store and drives the MEM/WB pipeline register toward writeback.
- Provides the writeback result mux output ResultW for the register file.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/memory_cycle_data_mem.sv | 26 ++
 rtl/memory_cycle.sv | 81 ++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the RV32 datapath stages.
package pipeline_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // ResultSrc encoding: which value the writeback mux selects.
    localparam logic RESULT_ALU = 1'b0;
    localparam logic RESULT_MEM = 1'b1;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic              reg_write;
        logic              result_src;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   read_data;
    } mem_wb_t;

endpackage

// File: rtl/memory_cycle_data_mem.sv
// Word-addressed data memory: asynchronous read, synchronous write, no reset.
module data_mem
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd
);

    logic [XLEN-1:0] mem [DEPTH];

    // Store path: new data lands at the edge, so a same-cycle read still sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wd;
        end
    end

    assign rd = mem[addr];

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: data-memory access plus the MEM/WB register and writeback result mux.
module memory_cycle
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 1024  // words; must be a power of two so the index wraps cleanly
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [REG_AW-1:0] RdM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [REG_AW-1:0] RdW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   ResultW
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   word_idx;
    logic            mem_we;
    logic [XLEN-1:0] mem_rd;
    mem_wb_t         mem_wb_q;
    mem_wb_t         mem_wb_d;

    // Byte offset bits are dropped (word accesses only); high bits are dropped so
    // addresses alias modulo the memory size.
    assign word_idx = ALUResultM[AW+1:2];

    // Stores are suppressed for as long as reset is held, not just at the edge.
    assign mem_we = MemWriteM & ~rst;

    data_mem #(
        .DEPTH (DEPTH)
    ) u_data_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (word_idx),
        .wd   (WriteDataM),
        .rd   (mem_rd)
    );

    // Next MEM/WB contents: every M-stage field plus the load data, no stall or flush.
    always_comb begin
        mem_wb_d            = '0;
        mem_wb_d.reg_write  = RegWriteM;
        mem_wb_d.result_src = ResultSrcM;
        mem_wb_d.rd         = RdM;
        mem_wb_d.pc_plus4   = PCPlus4M;
        mem_wb_d.alu_result = ALUResultM;
        mem_wb_d.read_data  = mem_rd;
    end

    // MEM/WB pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign RegWriteW  = mem_wb_q.reg_write;
    assign ResultSrcW = mem_wb_q.result_src;
    assign RdW        = mem_wb_q.rd;
    assign PCPlus4W   = mem_wb_q.pc_plus4;
    assign ALUResultW = mem_wb_q.alu_result;
    assign ReadDataW  = mem_wb_q.read_data;

    // Writeback selection purely from registered values.
    assign ResultW = (mem_wb_q.result_src == RESULT_MEM) ? mem_wb_q.read_data
                                                         : mem_wb_q.alu_result;

endmodule
